// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline with data-memory timeout.
// Optional perf counters are enabled with the HAZARD_PERF_CNT_EN macro.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  err,
    output logic [15:0]           stall_cycles,
    output logic [15:0]           flush_count
);
    typedef enum logic [1:0] {RUN, DWAIT, ERR} state_t;
    state_t      state;
    logic [15:0] wait_cnt;
    logic        lu, miss_start, advance, branch;
    assign lu = ex_mem_read && ex_rd != '0 &&
                ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    assign miss_start = state == RUN && dmem_req && !dmem_ready;
    // the pipeline moves only in RUN without a new miss, or on the completing DWAIT cycle
    assign advance = !rst && !miss_start && (state == RUN || (state == DWAIT && dmem_ready));
    assign branch  = advance && ex_branch_taken;
    assign err     = !rst && state == ERR;
    always_comb begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
        if_id_flush = rst;
        id_ex_flush = rst;
        if (advance) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '1;
            if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (lu) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!imem_ready) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (miss_start) begin
                    state    <= DWAIT;
                    wait_cnt <= 16'd1;
                end
                DWAIT: if (dmem_ready) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (wait_cnt == 16'(MEM_TIMEOUT)) state <= ERR;
                end
                ERR: state <= ERR;
                default: state <= RUN;
            endcase
        end
    end
`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
            if (branch && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
        end
    end
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
    logic unused_branch;
    assign unused_branch = branch;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed test-plan sequences plus random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_req, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, err;
    logic [15:0] stall_cycles, flush_count;
    int errors = 0, checks = 0;
    int m_state = 0, m_wait = 0, m_stall = 0, m_flush = 0;
    logic [7:0] last;

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .err(err),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // control vector {pc,if_id,id_ex,ex_mem,mem_wb,if_flush,id_flush,err} straight from the rules
    function automatic logic [7:0] model_ctl();
        logic hz;
        hz = ex_mem_read && ex_rd != 0 &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (rst) return 8'b00000_11_0;
        if (m_state == 2) return 8'b00000_00_1;
        if ((m_state == 0 && dmem_req && !dmem_ready) || (m_state == 1 && !dmem_ready))
            return 8'b00000_00_0;
        if (ex_branch_taken) return 8'b11111_11_0;
        if (hz) return 8'b00111_01_0;
        if (!imem_ready) return 8'b01111_10_0;
        return 8'b11111_00_0;
    endfunction

    function automatic logic [15:0] perf(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return 16'(v);
`else
        return 16'(0 * v);
`endif
    endfunction

    task automatic cyc(input string tag);
        logic [7:0] e;
        @(negedge clk);
        e = model_ctl();
        last = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, err};
        chk({tag, "/ctl"}, 32'(last), 32'(e));
        chk({tag, "/stall"}, 32'(stall_cycles), 32'(perf(m_stall)));
        chk({tag, "/flush"}, 32'(flush_count), 32'(perf(m_flush)));
        if (rst) begin
            m_state = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e[7] && m_stall < 65535) m_stall++;
            if (e == 8'b11111_11_0 && m_flush < 65535) m_flush++;
            if (m_state == 0 && dmem_req && !dmem_ready) begin
                m_state = 1; m_wait = 1;
            end else if (m_state == 1) begin
                if (dmem_ready) begin
                    m_state = 0; m_wait = 0;
                end else begin
                    if (m_wait == TO) m_state = 2;
                    m_wait++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_branch_taken = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic set_lu();
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 1;
    endtask

    initial begin
        rst = 1; idle();
        cyc("rst0");
        chk("rst_vec", 32'(last), 32'(8'b00000_11_0));
        cyc("rst1");
        rst = 0;
        cyc("first");
        chk("first_run", 32'(last), 32'(8'b11111_00_0));
        set_lu();
        cyc("lu");
        chk("lu_vec", 32'(last), 32'(8'b00111_01_0));
        idle();
        cyc("lu_next");
        chk("lu_resume", 32'(last), 32'(8'b11111_00_0));
        set_lu(); ex_branch_taken = 1; imem_ready = 0;
        cyc("br_hz");
        chk("br_over_hz", 32'(last), 32'(8'b11111_11_0));
        idle(); dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cyc("dwait");
            chk("dwait_frz", 32'(last[7:3]), 32'h0);
        end
        dmem_ready = 1;
        cyc("dwait_done");
        chk("dwait_go", 32'(last[7:3]), 32'h1f);
        idle();
        cyc("after_wait");
        chk("back_run", 32'(last), 32'(8'b11111_00_0));
        imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            cyc("fmiss");
            chk("fmiss_vec", 32'(last), 32'(8'b01111_10_0));
        end
        idle(); ex_branch_taken = 1;
        cyc("br2");
        idle();
        cyc("perf");
        chk("perf_stall", 32'(stall_cycles), 32'(perf(6)));
        chk("perf_flush", 32'(flush_count), 32'(perf(2)));
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("to_wait");
            chk("to_noerr", 32'(last[0]), 32'h0);
        end
        cyc("to_err");
        chk("to_err", 32'(last[0]), 32'h1);
        dmem_ready = 1;
        cyc("to_sticky");
        chk("to_sticky", 32'(last), 32'(8'b00000_00_1));
        rst = 1;
        cyc("to_rst");
        chk("to_rst_err", 32'(last[0]), 32'h0);
        rst = 0; idle();
        cyc("to_clear");
        chk("to_clear", 32'(last), 32'(8'b11111_00_0));
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(63) == 0);
            id_rs1 = 5'($urandom_range(3)); id_rs2 = 5'($urandom_range(3));
            ex_rd = 5'($urandom_range(3));
            id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
            ex_mem_read = 1'($urandom);
            ex_branch_taken = ($urandom_range(7) == 0);
            imem_ready = ($urandom_range(4) != 0);
            dmem_req = ($urandom_range(5) == 0);
            dmem_ready = ($urandom_range(4) > 1);
            cyc("rand");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage RISC pipeline (IF, ID, EX, MEM, WB). It sequences the pipeline by driving the PC enable, per-stage register enables and bubble/flush strobes. It resolves load-use hazards, taken branches, instruction-fetch misses and multi-cycle data-memory accesses. A timeout watchdog catches a hung data memory. It sits beside the pipeline datapath and owns no datapath state.

## Interface
Reset is synchronous and active-high.

Parameters:
- REG_ADDR_W, 5, register-index width
- MEM_TIMEOUT, 255, maximum DWAIT cycles before error (1..65535)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the corresponding source is read
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- imem_ready  in  1  fetch data valid this cycle
- dmem_req  in  1  MEM stage issues a data access
- dmem_ready  in  1  data access completes this cycle
- pc_en  out  1  PC update enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register enables
- if_id_flush, id_ex_flush  out  1  load bubble (NOP) into the register
- err  out  1  data-memory timeout, sticky until reset
- stall_cycles  out  16  stall-cycle counter (see Configuration)
- flush_count  out  16  taken-branch flush counter (see Configuration)

## Operation
The FSM has three states: RUN, DWAIT, ERR. The only registered state is the FSM state, a 16-bit wait counter, and the optional perf counters. All control outputs are combinational from the state and the current inputs.

Load-use hazard (lu): ex_mem_read AND ex_rd≠0 AND ((id_uses_rs1 AND id_rs1==ex_rd) OR (id_uses_rs2 AND id_rs2==ex_rd)).

In RUN (and in DWAIT on a cycle with dmem_ready=1), cases apply in priority order; the first matching case wins:
1. dmem_req AND NOT dmem_ready: every enable = 0, both flushes = 0. Next state DWAIT; wait counter = 1.
2. ex_branch_taken: all enables = 1, if_id_flush = 1, id_ex_flush = 1. The PC loads the target. A coincident lu or fetch miss is ignored.
3. lu: pc_en = 0, if_id_en = 0, id_ex_flush = 1, id_ex_en = ex_mem_en = mem_wb_en = 1.
4. NOT imem_ready: pc_en = 0, if_id_flush = 1, all other enables = 1.
5. Otherwise: all enables = 1, both flushes = 0.

In DWAIT with dmem_ready=0:
- Every enable = 0; the wait counter increments.
- When the counter equals MEM_TIMEOUT, the next state is ERR.

In DWAIT with dmem_ready=1:
- Evaluate cases 2-5 above (case 1 is suppressed for that cycle).
- Next state is RUN; the counter clears.

In ERR: every enable = 0, both flushes = 0, err = 1. Only rst exits this state.

While rst=1:
- Enables = 0, if_id_flush = id_ex_flush = 1, err = 0.
- The FSM goes to RUN; all counters go to 0.
- Reset mid-DWAIT abandons the access.

## Timing
- Hazard response has zero latency: outputs react in the same cycle as the inputs.
- The first cycle after rst deasserts is RUN with all enables = 1 (absent hazards).
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM, lu is false, and the pipeline resumes.
- A taken branch costs 2 squashed slots, flushed in a single cycle.
- DWAIT costs N cycles of full freeze for N cycles with dmem_ready=0. The pipeline advances on the cycle dmem_ready=1.
- Timeout: err rises on the cycle after the counter reaches MEM_TIMEOUT. The counter wraps only through reset.
- All inputs are sampled on the rising edge of clk. Inputs are assumed stable while frozen.

## Configuration
Macro: HAZARD_PERF_CNT_EN.
- Defined: stall_cycles increments on every cycle with pc_en=0 outside reset (DWAIT, ERR, lu, fetch miss). flush_count increments on every case-2 cycle. Both saturate at 16'hFFFF and clear on rst.
- Not defined: no counter registers are built; both outputs are tied to 16'h0000.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; all enables = 1 the next cycle.
- Branch over hazard: ex_branch_taken=1 together with the load-use inputs above → pc_en=1, if_id_flush=1, id_ex_flush=1, if_id_en=1.
- Data wait: dmem_req=1, dmem_ready=0 for 3 cycles then 1 → enables = 0 for 3 cycles, all 1 on the 4th; FSM returns to RUN.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, dmem_ready held 0 → err=1 from the 5th cycle after entry, stays 1 even after dmem_ready=1; rst clears it.
- Fetch miss: imem_ready=0 for 2 cycles → pc_en=0, if_id_flush=1, id_ex_en=1 both cycles.
- Perf counters, with HAZARD_PERF_CNT_EN defined: the load-use, 3-cycle wait and 2-cycle fetch-miss sequences → stall_cycles=6; 2 taken branches → flush_count=2. Without the macro, both outputs read 0.
